// File: rtl/counter_btn_ctrl.sv
// Push-button front end for updown_counter: synchronise, debounce and edge-detect
// three buttons, arbitrate the resulting events and register the switch load word.
module counter_btn_ctrl #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_load,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [3:0] sw,
    output logic       load,
    output logic       enable,
    output logic       up_down,
    output logic [3:0] d_in,
    output logic       drop
);

    localparam int NUM_BTN  = 3;
    localparam int BTN_LOAD = 0;
    localparam int BTN_UP   = 1;
    localparam int BTN_DOWN = 2;
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    // db toggles on the sample that would bring cnt up to DEBOUNCE_CYCLES
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_evt;

    assign btn_raw = {btn_down, btn_up, btn_load};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            logic             sync1_reg;
            logic             sync2_reg;
            logic             db_reg;
            logic             db_prev_reg;
            logic [CNT_W-1:0] cnt_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    sync1_reg   <= 1'b0;
                    sync2_reg   <= 1'b0;
                    db_reg      <= 1'b0;
                    db_prev_reg <= 1'b0;
                    cnt_reg     <= '0;
                end else begin
                    sync1_reg   <= btn_raw[gi];
                    sync2_reg   <= sync1_reg;
                    db_prev_reg <= db_reg;
                    if (sync2_reg == db_reg) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        db_reg  <= ~db_reg;
                        cnt_reg <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + CNT_W'(1);
                    end
                end
            end

            // Only a press (accepted 0->1) is a command; releases are silent.
            assign btn_evt[gi] = db_reg & ~db_prev_reg;
        end
    endgenerate

    logic [3:0] sw_sync1_reg;
    logic [3:0] sw_sync2_reg;
    logic       load_reg;
    logic       enable_reg;
    logic       up_down_reg;
    logic [3:0] d_in_reg;
    logic       drop_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_sync1_reg <= '0;
            sw_sync2_reg <= '0;
            load_reg     <= 1'b0;
            enable_reg   <= 1'b0;
            up_down_reg  <= 1'b1;
            d_in_reg     <= '0;
            drop_reg     <= 1'b0;
        end else begin
            sw_sync1_reg <= sw;
            sw_sync2_reg <= sw_sync1_reg;
            load_reg     <= 1'b0;
            enable_reg   <= 1'b0;
            drop_reg     <= 1'b0;
            if (btn_evt[BTN_LOAD]) begin
                load_reg <= 1'b1;
                d_in_reg <= sw_sync2_reg;
                drop_reg <= btn_evt[BTN_UP] | btn_evt[BTN_DOWN];
            end else if (btn_evt[BTN_UP] && btn_evt[BTN_DOWN]) begin
                // Conflicting directions: discard both, keep the old direction.
                drop_reg <= 1'b1;
            end else if (btn_evt[BTN_UP]) begin
                enable_reg  <= 1'b1;
                up_down_reg <= 1'b1;
            end else if (btn_evt[BTN_DOWN]) begin
                enable_reg  <= 1'b1;
                up_down_reg <= 1'b0;
            end
        end
    end

    assign load    = load_reg;
    assign enable  = enable_reg;
    assign up_down = up_down_reg;
    assign d_in    = d_in_reg;
    assign drop    = drop_reg;

endmodule

// File: tb/tb_counter_btn_ctrl.sv
// Bench for counter_btn_ctrl: directed test-plan scenarios plus random button
// activity, every cycle compared against a history-based reference model.
module tb_counter_btn_ctrl;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_load = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic [3:0] sw = 4'h0;
    logic       load;
    logic       enable;
    logic       up_down;
    logic [3:0] d_in;
    logic       drop;

    int checks = 0;
    int errors = 0;

    counter_btn_ctrl #(.DEBOUNCE_CYCLES(D)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_load (btn_load),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .sw       (sw),
        .load     (load),
        .enable   (enable),
        .up_down  (up_down),
        .d_in     (d_in),
        .drop     (drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: keeps the raw sample history since reset and applies the
    // debounce rule "D consecutive synchronised samples disagreeing with db".
    logic [2:0] raw_q[$];
    logic [3:0] sw_q[$];
    int         m_k;
    logic [2:0] m_db;
    logic [2:0] m_rose;
    int         m_last[3];
    logic       exp_load, exp_enable, exp_up_down, exp_drop;
    logic [3:0] exp_d_in;

    function automatic logic seen_at(input int b, input int j);
        logic [2:0] v;
        if (j < 2) return 1'b0;
        v = raw_q[j-2];
        return v[b];
    endfunction

    task automatic model_reset();
        raw_q.delete();
        sw_q.delete();
        m_k = 0;
        m_db = '0;
        m_rose = '0;
        for (int b = 0; b < 3; b++) m_last[b] = -1;
        exp_load = 0; exp_enable = 0; exp_up_down = 1; exp_drop = 0; exp_d_in = '0;
    endtask

    task automatic model_step();
        logic [2:0] evt;
        logic       all_diff;
        evt = m_rose;
        m_rose = '0;
        exp_load = 0; exp_enable = 0; exp_drop = 0;
        if (evt[0]) begin
            exp_load = 1;
            exp_d_in = (m_k >= 2) ? sw_q[m_k-2] : 4'h0;
            exp_drop = evt[1] | evt[2];
        end else if (evt[1] && evt[2]) begin
            exp_drop = 1;
        end else if (evt[1]) begin
            exp_enable = 1; exp_up_down = 1;
        end else if (evt[2]) begin
            exp_enable = 1; exp_up_down = 0;
        end
        for (int b = 0; b < 3; b++) begin
            if (m_k - m_last[b] >= D) begin
                all_diff = 1'b1;
                for (int j = m_k - D + 1; j <= m_k; j++)
                    if (seen_at(b, j) == m_db[b]) all_diff = 1'b0;
                if (all_diff) begin
                    m_db[b] = ~m_db[b];
                    m_last[b] = m_k;
                    if (m_db[b]) m_rose[b] = 1'b1;
                end
            end
        end
        raw_q.push_back({btn_down, btn_up, btn_load});
        sw_q.push_back(sw);
        m_k++;
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_step();
        end
    end

    int cnt_load = 0, cnt_enable = 0, cnt_drop = 0;

    initial begin
        #3;
        forever begin
            @(negedge clk);
            check("load", load, exp_load);
            check("enable", enable, exp_enable);
            check("up_down", up_down, exp_up_down);
            check("d_in", d_in, exp_d_in);
            check("drop", drop, exp_drop);
            check("excl", load & enable, 0);
            cnt_load += int'(load);
            cnt_enable += int'(enable);
            cnt_drop += int'(drop);
        end
    end

    task automatic drive(input logic [2:0] v);
        @(negedge clk);
        {btn_down, btn_up, btn_load} = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Index i means "observed just after edge i", edge 0 being the first sample.
    task automatic watch(input int n, input bit sel_enable, output int first, output int count);
        first = -1;
        count = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (sel_enable ? enable : load) begin
                if (first < 0) first = i;
                count++;
            end
        end
    endtask

    int first, cnt, cnt2, l0, e0, d0;
    int hold[3];

    initial begin
        #1 rst = 1'b1;
        idle(2);
        check("rst_load", load, 0);
        check("rst_enable", enable, 0);
        check("rst_drop", drop, 0);
        check("rst_up_down", up_down, 1);
        check("rst_d_in", d_in, 0);
        rst = 1'b0;
        $display("reset done");

        sw = 4'h7;
        idle(3);
        drive(3'b001);
        watch(20, 1'b0, first, cnt);
        drive(3'b000);
        watch(12, 1'b0, d0, cnt2);
        check("load_latency", first, D + 2);
        check("load_count", cnt, 1);
        check("load_release", cnt2, 0);
        check("load_d_in", d_in, 4'h7);
        $display("clean load: latency %0d pulses %0d", first, cnt);

        e0 = cnt_enable;
        repeat (4) begin
            drive(3'b010);
            idle(2);
            drive(3'b000);
        end
        drive(3'b010);
        check("bounce_quiet", cnt_enable - e0, 0);
        watch(12, 1'b1, first, cnt);
        check("bounce_latency", first, D + 2);
        check("bounce_count", cnt, 1);
        check("bounce_dir", up_down, 1);
        drive(3'b000);
        idle(12);
        $display("bounce: latency %0d pulses %0d", first, cnt);

        drive(3'b100);
        watch(12, 1'b1, first, cnt);
        check("down_count", cnt, 1);
        check("down_dir", up_down, 0);
        drive(3'b000);
        idle(12);
        check("down_hold", up_down, 0);
        $display("down press: pulses %0d", cnt);

        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_up_down", up_down, 1);
        check("arst_d_in", d_in, 0);
        idle(2);
        rst = 1'b0;
        $display("mid-cycle reset");

        drive(3'b010);
        watch(12, 1'b1, first, cnt);
        check("up_count", cnt, 1);
        check("up_dir", up_down, 1);
        drive(3'b000);
        idle(12);
        $display("up press: pulses %0d", cnt);

        sw = 4'hA;
        l0 = cnt_load; e0 = cnt_enable; d0 = cnt_drop;
        drive(3'b011);
        idle(12);
        drive(3'b000);
        idle(12);
        check("ld_up_load", cnt_load - l0, 1);
        check("ld_up_enable", cnt_enable - e0, 0);
        check("ld_up_drop", cnt_drop - d0, 1);
        check("ld_up_d_in", d_in, 4'hA);
        $display("load+up simultaneous");

        drive(3'b100);
        idle(12);
        drive(3'b000);
        idle(12);
        e0 = cnt_enable; d0 = cnt_drop;
        drive(3'b110);
        idle(12);
        drive(3'b000);
        idle(12);
        check("ud_enable", cnt_enable - e0, 0);
        check("ud_drop", cnt_drop - d0, 1);
        check("ud_dir", up_down, 0);
        $display("up+down simultaneous");

        e0 = cnt_enable;
        drive(3'b010);
        idle(2);
        rst = 1'b1;
        idle(2);
        check("rstdb_quiet", cnt_enable - e0, 0);
        rst = 1'b0;
        watch(12, 1'b1, first, cnt);
        check("rstdb_latency", first, D + 2);
        check("rstdb_count", cnt, 1);
        drive(3'b000);
        idle(12);
        $display("reset mid-debounce: latency %0d", first);

        for (int b = 0; b < 3; b++) hold[b] = 0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int b = 0; b < 3; b++) begin
                if (hold[b] == 0) begin
                    hold[b] = int'($urandom_range(1, 9));
                    case (b)
                        0: btn_load = 1'($urandom_range(0, 1));
                        1: btn_up = 1'($urandom_range(0, 1));
                        default: btn_down = 1'($urandom_range(0, 1));
                    endcase
                end
                hold[b]--;
            end
            if ($urandom_range(0, 3) == 0) sw = 4'($urandom);
        end
        drive(3'b000);
        idle(15);
        $display("random phase: loads %0d enables %0d drops %0d", cnt_load, cnt_enable, cnt_drop);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
